// File: rtl/phys_reg_free_list_if.sv
// Purpose: handshake bundle between rename/commit and the physical register
//          free list.
// Signals:
//   alloc_req     rename -> list   request one free tag this cycle
//   alloc_valid   list -> rename   a free tag is offered on alloc_tag
//   alloc_tag     list -> rename   offered tag
//   release_valid commit -> list   a tag is returned this cycle
//   release_tag   commit -> list   returned tag
//   free_count    list -> any      number of tags held in the list
//   err           list -> any      sticky protocol-error flag
// Modports: master (rename/commit side), slave (free list).
interface phys_reg_free_list_if #(
  parameter int TAG_W = 6
);
  logic             alloc_req;
  logic             alloc_valid;
  logic [TAG_W-1:0] alloc_tag;
  logic             release_valid;
  logic [TAG_W-1:0] release_tag;
  logic [TAG_W-1:0] free_count;
  logic             err;

  modport master (
    output alloc_req, release_valid, release_tag,
    input  alloc_valid, alloc_tag, free_count, err
  );

  modport slave (
    input  alloc_req, release_valid, release_tag,
    output alloc_valid, alloc_tag, free_count, err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Purpose: circular FIFO free list of physical register tags. Rename pops one
//          tag per cycle from the head, commit pushes superseded tags at the
//          tail. An in_list vector rejects double releases; a push into a full
//          list without a same-cycle pop is an overflow. Both raise a sticky err.
// Ports:
//   clk  clock
//   rst  asynchronous, active-high reset
//   fl   phys_reg_free_list_if.slave (alloc/release handshake, free_count, err)
// Optional feature: define FREE_LIST_BYPASS_EN to hand a released tag straight
//          to a requesting allocator when the list is empty.
module phys_reg_free_list #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int TAG_W     = 6
) (
  input logic                 clk,
  input logic                 rst,
  phys_reg_free_list_if.slave fl
);
  localparam int DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic [PHYS_REGS-1:0] in_list;
  logic                 err_q;

  logic empty;
  logic full;
  logic rel_fresh;
  logic pop;
  logic push;
  logic bypass_take;
  logic reject;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  // A tag may only come back if it is not already sitting in the list.
  assign rel_fresh = fl.release_valid && !in_list[fl.release_tag];
  assign pop       = fl.alloc_req && !empty;

`ifdef FREE_LIST_BYPASS_EN
  logic bypass;
  // Empty list plus a legal release: offer the released tag directly.
  assign bypass         = empty && rel_fresh;
  assign bypass_take    = bypass && fl.alloc_req;
  assign fl.alloc_valid = !empty || bypass;
  assign fl.alloc_tag   = bypass ? fl.release_tag : mem[head];
`else
  assign bypass_take    = 1'b0;
  assign fl.alloc_valid = !empty;
  assign fl.alloc_tag   = mem[head];
`endif

  // A full list still accepts a release when a pop frees a slot this cycle.
  assign push   = rel_fresh && !bypass_take && (!full || pop);
  assign reject = fl.release_valid && !push && !bypass_take;

  assign fl.free_count = TAG_W'(count);
  assign fl.err        = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= TAG_W'(ARCH_REGS + i);
      end
      for (int t = 0; t < PHYS_REGS; t++) begin
        in_list[t] <= (t >= ARCH_REGS);
      end
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(DEPTH);
      err_q <= 1'b0;
    end else begin
      if (pop) begin
        head              <= ptr_inc(head);
        in_list[mem[head]] <= 1'b0;
      end
      if (push) begin
        mem[tail]                <= fl.release_tag;
        tail                     <= ptr_inc(tail);
        in_list[fl.release_tag] <= 1'b1;
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (reject) begin
        err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;
  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int TAG_W     = 6;
  localparam int DEPTH     = PHYS_REGS - ARCH_REGS;
`ifdef FREE_LIST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  phys_reg_free_list_if #(.TAG_W(TAG_W)) fl ();

  phys_reg_free_list #(
    .PHYS_REGS(PHYS_REGS),
    .ARCH_REGS(ARCH_REGS),
    .TAG_W    (TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fl (fl.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the list is a plain queue of tags in allocation order.
  int q[$];
  bit m_in_list[PHYS_REGS];
  bit m_err;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int t = 0; t < PHYS_REGS; t++) m_in_list[t] = 1'b0;
    for (int t = ARCH_REGS; t < PHYS_REGS; t++) begin
      q.push_back(t);
      m_in_list[t] = 1'b1;
    end
    m_err = 1'b0;
  endtask

  function automatic bit model_bypass();
    return BYP && (q.size() == 0) && fl.release_valid &&
           !m_in_list[int'(fl.release_tag)];
  endfunction

  task automatic model_step();
    int  rt;
    bit  fresh;
    bit  take;
    bit  do_pop;
    int  t;
    rt     = int'(fl.release_tag);
    fresh  = fl.release_valid && !m_in_list[rt];
    take   = model_bypass() && fl.alloc_req;
    do_pop = fl.alloc_req && (q.size() != 0);
    if (do_pop) begin
      t = q.pop_front();
      m_in_list[t] = 1'b0;
    end
    if (fresh && !take && (q.size() < DEPTH)) begin
      q.push_back(rt);
      m_in_list[rt] = 1'b1;
    end else if (fl.release_valid && !take) begin
      m_err = 1'b1;
    end
  endtask

  task automatic compare();
    bit exp_valid;
    int exp_tag;
    exp_valid = (q.size() != 0) || model_bypass();
    exp_tag   = model_bypass() ? int'(fl.release_tag) : ((q.size() != 0) ? q[0] : 0);
    check("alloc_valid", int'(fl.alloc_valid), int'(exp_valid));
    if (exp_valid) check("alloc_tag", int'(fl.alloc_tag), exp_tag);
    check("free_count", int'(fl.free_count), q.size());
    check("err", int'(fl.err), int'(m_err));
  endtask

  // One cycle: commit the previous inputs at the edge, drive new ones at the
  // falling edge, then check outputs against the model.
  task automatic drive(input bit req, input bit rv, input int rt);
    @(posedge clk);
    model_step();
    @(negedge clk);
    fl.alloc_req     = req;
    fl.release_valid = rv;
    fl.release_tag   = TAG_W'(rt);
    #1;
    compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    fl.alloc_req     = 1'b0;
    fl.release_valid = 1'b0;
    fl.release_tag   = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int rt;
    rst              = 1'b1;
    fl.alloc_req     = 1'b0;
    fl.release_valid = 1'b0;
    fl.release_tag   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    drive(0, 0, 0);
    check("rst_valid", int'(fl.alloc_valid), 1);
    check("rst_tag", int'(fl.alloc_tag), 32);
    check("rst_count", int'(fl.free_count), 32);
    check("rst_err", int'(fl.err), 0);

    // Drain the list in order.
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0);
      check("drain_tag", int'(fl.alloc_tag), 32 + i);
      check("drain_count", int'(fl.free_count), 32 - i);
    end
    drive(1, 0, 0);
    check("empty_valid", int'(fl.alloc_valid), 0);
    check("empty_count", int'(fl.free_count), 0);
    drive(0, 0, 0);
    check("empty_hold", int'(fl.free_count), 0);
    check("empty_err", int'(fl.err), 0);

    // Refill from empty, then wrap through the pointers.
    drive(0, 1, 5);
    drive(1, 0, 0);
    check("rel5_tag", int'(fl.alloc_tag), 5);
    check("rel5_count", int'(fl.free_count), 1);
    drive(0, 1, 7);
    check("rel5_after", int'(fl.free_count), 0);
    drive(0, 1, 9);
    drive(0, 1, 11);
    drive(1, 0, 0);
    check("wrap_count", int'(fl.free_count), 3);
    check("wrap_tag0", int'(fl.alloc_tag), 7);
    drive(1, 0, 0);
    check("wrap_tag1", int'(fl.alloc_tag), 9);
    drive(1, 0, 0);
    check("wrap_tag2", int'(fl.alloc_tag), 11);
    drive(0, 0, 0);
    check("wrap_empty", int'(fl.alloc_valid), 0);

    // Release into an empty list with a concurrent request.
    drive(1, 1, 12);
    check("byp_valid", int'(fl.alloc_valid), BYP ? 1 : 0);
    if (BYP) check("byp_tag", int'(fl.alloc_tag), 12);
    drive(0, 0, 0);
    check("byp_count", int'(fl.free_count), BYP ? 0 : 1);
    if (!BYP) check("nobyp_tag", int'(fl.alloc_tag), 12);
    check("byp_err", int'(fl.err), 0);

    // Simultaneous pop and push on a full list, then a double release.
    do_reset();
    drive(1, 1, 3);
    check("full_pp_tag", int'(fl.alloc_tag), 32);
    drive(0, 1, 40);
    check("full_pp_count", int'(fl.free_count), 32);
    check("full_pp_err", int'(fl.err), 0);
    drive(0, 0, 0);
    check("dbl_err", int'(fl.err), 1);
    check("dbl_count", int'(fl.free_count), 32);
    for (int i = 0; i < 31; i++) drive(1, 0, 0);
    drive(1, 0, 0);
    check("tail_tag", int'(fl.alloc_tag), 3);
    drive(0, 0, 0);

    // Randomized traffic, mostly legal releases, with a reset midway.
    for (int c = 0; c < 1600; c++) begin
      if (c == 800) do_reset();
      rt = $urandom_range(0, PHYS_REGS - 1);
      if ($urandom_range(0, 9) < 8) begin
        for (int k = 0; k < PHYS_REGS; k++) begin
          if (!m_in_list[(rt + k) % PHYS_REGS]) begin
            rt = (rt + k) % PHYS_REGS;
            break;
          end
        end
      end
      drive($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 45, rt);
    end

    // Asynchronous reset mid-stream.
    do_reset();
    drive(0, 1, 40);
    for (int i = 0; i < 15; i++) drive(1, 0, 0);
    drive(0, 0, 0);
    check("mid_count", int'(fl.free_count), 17);
    check("mid_err", int'(fl.err), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_valid", int'(fl.alloc_valid), 1);
    check("arst_tag", int'(fl.alloc_tag), 32);
    check("arst_count", int'(fl.free_count), 32);
    check("arst_err", int'(fl.err), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0);
    check("restart_tag0", int'(fl.alloc_tag), 32);
    drive(1, 0, 0);
    check("restart_tag1", int'(fl.alloc_tag), 33);
    drive(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
